frame_capture_writer: RTL and testbench

Write-side address and data generator for the 320x240 stereo frame buffers. It consumes one camera's byte stream (vsync, href, byte strobe), assembles RGB565 pixels, optionally decimates 2:1 in both axes, and emits 17-bit raster write addresses with RGB444 data and a write enable. The display/rectification path later reads the same buffer with raster addresses. One instance per camera, left and right.

---
 rtl/stereo_pkg.sv | 20 ++
 rtl/pixel_pair_assembler.sv | 38 +++
 rtl/frame_capture_writer.sv | 139 +++++++++++++
 tb/tb_frame_capture_writer.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stereo_pkg.sv
// Shared definitions for the stereo frame buffer write and display paths.
// Holds the capture state encoding, default geometry and the RGB565->RGB444 reduction.
package stereo_pkg;

  localparam int unsigned DEF_H_ACTIVE = 320;
  localparam int unsigned DEF_V_ACTIVE = 240;
  localparam int unsigned DEF_ADDR_W   = 17;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_BLANK  = 2'd1,
    ST_ACTIVE = 2'd2
  } capture_state_t;

  // Keep the top four bits of each colour field.
  function automatic logic [11:0] rgb565_to_rgb444(input logic [15:0] px);
    return {px[15:12], px[10:7], px[4:1]};
  endfunction

endpackage

// File: rtl/pixel_pair_assembler.sv
// Pairs camera bytes into 16-bit pixels: first byte of a pair is the high byte.
// A clear (href edge or not capturing) restarts pairing, so an odd trailing byte is dropped.
module pixel_pair_assembler (
  input  logic        CLK,
  input  logic        RST,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic        pix_valid,
  output logic [15:0] pix_data
);

  logic       phase_q;
  logic [7:0] hi_q;
  logic       phase_eff;

  // A byte arriving on the same cycle as the href edge starts a fresh pair.
  assign phase_eff = phase_q & ~clear;
  assign pix_valid = accept & phase_eff;
  assign pix_data  = {hi_q, byte_in};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      phase_q <= 1'b0;
      hi_q    <= 8'd0;
    end else if (accept) begin
      if (!phase_eff) begin
        hi_q    <= byte_in;
        phase_q <= 1'b1;
      end else begin
        phase_q <= 1'b0;
      end
    end else if (clear) begin
      phase_q <= 1'b0;
    end
  end

endmodule

// File: rtl/frame_capture_writer.sv
// Camera byte stream to raster frame-buffer writes (RGB444), optional 2:1 decimation.
// Owns the vsync FSM, line/column counters and write address generation.
module frame_capture_writer
  import stereo_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter bit          DECIMATE = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_byte,
  input  logic              cam_byte_valid,
  output logic [ADDR_W-1:0] address_out,
  output logic [11:0]       pixel_out,
  output logic              we,
  output logic              frame_done,
  output logic              overrun
);

  localparam int unsigned CW = $clog2(H_ACTIVE + 1);
  localparam int unsigned RW = $clog2(V_ACTIVE + 1);
  localparam logic [CW-1:0]     H_LIM  = CW'(H_ACTIVE);
  localparam logic [RW-1:0]     V_LIM  = RW'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_ACTIVE);

  capture_state_t    state;
  logic              vsync_q;
  logic              href_q;
  logic              cam_col_lsb;
  logic              cam_row_lsb;
  logic [CW-1:0]     out_col;
  logic [RW-1:0]     out_row;
  logic [ADDR_W-1:0] line_base;

  logic        vs_rise;
  logic        vs_fall;
  logic        href_fall;
  logic        accept;
  logic        clear;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        row_kept;
  logic        pix_kept;

  assign vs_rise   = cam_vsync & ~vsync_q;
  assign vs_fall   = ~cam_vsync & vsync_q;
  assign href_fall = ~cam_href & href_q;

  // vsync rising aborts any pixel still in flight on that cycle.
  assign accept = cam_href & cam_byte_valid & (state == ST_ACTIVE) & ~vs_rise;
  assign clear  = (cam_href ^ href_q) | (state != ST_ACTIVE);

  assign row_kept = !DECIMATE || !cam_row_lsb;
  assign pix_kept = row_kept && (!DECIMATE || !cam_col_lsb);

  pixel_pair_assembler u_pair (
    .CLK       (CLK),
    .RST       (RST),
    .clear     (clear),
    .accept    (accept),
    .byte_in   (cam_byte),
    .pix_valid (pix_valid),
    .pix_data  (pix_data)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= ST_SYNC;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      cam_col_lsb <= 1'b0;
      cam_row_lsb <= 1'b0;
      out_col     <= '0;
      out_row     <= '0;
      line_base   <= '0;
      address_out <= '0;
      pixel_out   <= 12'd0;
      we          <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      vsync_q    <= cam_vsync;
      href_q     <= cam_href;
      we         <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_SYNC: begin
          if (vs_rise) state <= ST_BLANK;
        end
        ST_BLANK: begin
          cam_col_lsb <= 1'b0;
          cam_row_lsb <= 1'b0;
          out_col     <= '0;
          out_row     <= '0;
          line_base   <= '0;
          if (vs_fall) state <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (vs_rise) begin
            frame_done <= 1'b1;
            state      <= ST_BLANK;
          end else begin
            if (pix_valid) begin
              cam_col_lsb <= ~cam_col_lsb;
              if (pix_kept) begin
                if (out_col < H_LIM && out_row < V_LIM) begin
                  we          <= 1'b1;
                  address_out <= line_base + ADDR_W'(out_col);
                  pixel_out   <= rgb565_to_rgb444(pix_data);
                end else begin
                  overrun <= 1'b1;
                end
                // Saturate so an over-long line cannot wrap back into range.
                if (out_col != H_LIM) out_col <= out_col + 1'b1;
              end
            end
            if (href_fall) begin
              cam_col_lsb <= 1'b0;
              cam_row_lsb <= ~cam_row_lsb;
              if (row_kept) begin
                out_col <= '0;
                if (out_row != V_LIM) begin
                  out_row   <= out_row + 1'b1;
                  line_base <= line_base + H_STEP;
                end
              end
            end
          end
        end
        default: state <= ST_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_capture_writer.sv
// Drives a 1:1 and a 2:1 decimating writer from one camera stream and
// compares their writes against a frame-level reference model.
module tb_frame_capture_writer;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int AW = 17;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       cam_vsync = 1'b0;
  logic       cam_href = 1'b0;
  logic       cam_byte_valid = 1'b0;
  logic [7:0] cam_byte = 8'd0;

  logic [AW-1:0] addr [2];
  logic [11:0]   pix  [2];
  logic          we   [2];
  logic          fd   [2];
  logic          ovr  [2];

  int checks = 0;
  int errors = 0;

  int          ga [2][$];
  logic [11:0] gp [2][$];
  int          fdc [2];
  int          ea [2][$];
  logic [11:0] ep [2][$];
  bit          eovr [2];

  logic [7:0] fbytes [$];
  int         flen [$];

  always #5 CLK = ~CLK;

  frame_capture_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .DECIMATE(1'b0)) dut0 (
    .CLK(CLK), .RST(RST), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_byte(cam_byte),
    .cam_byte_valid(cam_byte_valid), .address_out(addr[0]), .pixel_out(pix[0]), .we(we[0]),
    .frame_done(fd[0]), .overrun(ovr[0]));

  frame_capture_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .DECIMATE(1'b1)) dut1 (
    .CLK(CLK), .RST(RST), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_byte(cam_byte),
    .cam_byte_valid(cam_byte_valid), .address_out(addr[1]), .pixel_out(pix[1]), .we(we[1]),
    .frame_done(fd[1]), .overrun(ovr[1]));

  always @(negedge CLK) begin
    for (int d = 0; d < 2; d++) begin
      if (we[d]) begin
        ga[d].push_back(int'(addr[d]));
        gp[d].push_back(pix[d]);
      end
      if (fd[d]) fdc[d]++;
    end
  end

  task automatic clear_obs();
    for (int d = 0; d < 2; d++) begin
      ga[d].delete(); gp[d].delete(); ea[d].delete(); ep[d].delete(); fdc[d] = 0;
    end
  endtask

  task automatic new_frame();
    fbytes.delete();
    flen.delete();
  endtask

  // mode 0: random bytes, 1: F8/1F pairs, 2: pixel index in the red nibble
  task automatic add_line(input int n, input int mode);
    flen.push_back(n);
    for (int i = 0; i < n; i++) begin
      case (mode)
        1:       fbytes.push_back((i % 2 == 0) ? 8'hF8 : 8'h1F);
        2:       fbytes.push_back((i % 2 == 0) ? 8'((i / 2) << 4) : 8'h00);
        default: fbytes.push_back(8'($urandom_range(0, 255)));
      endcase
    end
  endtask

  // Expected writes from whole-frame geometry: pair bytes, pick kept rows/columns, place in raster.
  task automatic model_frame();
    for (int d = 0; d < 2; d++) begin
      int pos;
      int orow;
      pos = 0;
      orow = 0;
      for (int r = 0; r < flen.size(); r++) begin
        int  np;
        int  ocol;
        bit  rkeep;
        np = flen[r] / 2;
        ocol = 0;
        rkeep = (d == 0) || (r % 2 == 0);
        for (int c = 0; c < np; c++) begin
          logic [15:0] p;
          p = {fbytes[pos + 2 * c], fbytes[pos + 2 * c + 1]};
          if (rkeep && (d == 0 || c % 2 == 0)) begin
            if (ocol < H && orow < V) begin
              ea[d].push_back(orow * H + ocol);
              ep[d].push_back({p[15:12], p[10:7], p[4:1]});
            end else begin
              eovr[d] = 1'b1;
            end
            ocol++;
          end
        end
        pos += flen[r];
        if (rkeep) orow++;
      end
    end
  endtask

  task automatic drive_lines(input bit abort_last);
    int pos;
    pos = 0;
    for (int r = 0; r < flen.size(); r++) begin
      @(negedge CLK) cam_href = 1'b1;
      for (int b = 0; b < flen[r]; b++) begin
        int gap;
        gap = $urandom_range(0, 2);
        if (gap > 0) begin
          cam_byte_valid = 1'b0;
          repeat (gap) @(negedge CLK);
        end
        cam_byte = fbytes[pos + b];
        cam_byte_valid = 1'b1;
        @(negedge CLK);
      end
      cam_byte_valid = 1'b0;
      pos += flen[r];
      if (abort_last && r == flen.size() - 1) begin
        cam_vsync = 1'b1;
        repeat (2) @(negedge CLK);
        cam_href = 1'b0;
      end else begin
        cam_href = 1'b0;
        repeat ($urandom_range(2, 4)) @(negedge CLK);
      end
    end
  endtask

  task automatic drive_frame(input bit abort_last);
    @(negedge CLK) cam_vsync = 1'b1;
    repeat (3) @(negedge CLK);
    cam_vsync = 1'b0;
    repeat (2) @(negedge CLK);
    drive_lines(abort_last);
    if (!abort_last) cam_vsync = 1'b1;
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_reset();
    @(negedge CLK) RST = 1'b1;
    repeat (3) @(negedge CLK);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (we[d] !== 1'b0 || addr[d] !== '0 || pix[d] !== 12'd0 || fd[d] !== 1'b0 || ovr[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset dut%0d got we=%b addr=%0d pix=%h fd=%b ovr=%b exp all zero",
                 d, we[d], addr[d], pix[d], fd[d], ovr[d]);
      end
    end
    RST = 1'b0;
    eovr[0] = 1'b0;
    eovr[1] = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_basic();
    clear_obs(); new_frame();
    add_line(8, 1); add_line(8, 1);
    model_frame();
    drive_frame(1'b0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ga[d].size() != ea[d].size()) begin
        errors++; $display("FAIL basic_nwrites dut%0d got %0d exp %0d", d, ga[d].size(), ea[d].size());
      end
      for (int i = 0; i < ea[d].size() && i < ga[d].size(); i++) begin
        checks++;
        if (ga[d][i] !== ea[d][i] || gp[d][i] !== ep[d][i] || gp[d][i] !== 12'hF0F) begin
          errors++; $display("FAIL basic_write dut%0d #%0d got %0d/%h exp %0d/%h", d, i, ga[d][i], gp[d][i], ea[d][i], ep[d][i]);
        end
      end
      checks++;
      if (fdc[d] !== 1) begin errors++; $display("FAIL basic_frame_done dut%0d got %0d exp 1", d, fdc[d]); end
      checks++;
      if (ovr[d] !== eovr[d]) begin errors++; $display("FAIL basic_overrun dut%0d got %b exp %b", d, ovr[d], eovr[d]); end
    end
  endtask

  task automatic test_short_line();
    clear_obs(); new_frame();
    add_line(6, 0); add_line(8, 0);
    model_frame();
    drive_frame(1'b0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ga[d].size() != ea[d].size()) begin
        errors++; $display("FAIL short_nwrites dut%0d got %0d exp %0d", d, ga[d].size(), ea[d].size());
      end
      for (int i = 0; i < ea[d].size() && i < ga[d].size(); i++) begin
        checks++;
        if (ga[d][i] !== ea[d][i] || gp[d][i] !== ep[d][i]) begin
          errors++; $display("FAIL short_write dut%0d #%0d got %0d/%h exp %0d/%h", d, i, ga[d][i], gp[d][i], ea[d][i], ep[d][i]);
        end
      end
      checks++;
      if (ovr[d] !== 1'b0) begin errors++; $display("FAIL short_overrun dut%0d got %b exp 0", d, ovr[d]); end
    end
    checks++;
    if (ga[0].size() == 7 && ga[0][3] !== 4) begin
      errors++; $display("FAIL short_second_line_base got %0d exp 4", ga[0][3]);
    end
  endtask

  task automatic test_overrun();
    clear_obs(); new_frame();
    add_line(12, 0); add_line(8, 0);
    model_frame();
    drive_frame(1'b0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ga[d].size() != ea[d].size()) begin
        errors++; $display("FAIL ovr_nwrites dut%0d got %0d exp %0d", d, ga[d].size(), ea[d].size());
      end
      for (int i = 0; i < ea[d].size() && i < ga[d].size(); i++) begin
        checks++;
        if (ga[d][i] !== ea[d][i] || gp[d][i] !== ep[d][i]) begin
          errors++; $display("FAIL ovr_write dut%0d #%0d got %0d/%h exp %0d/%h", d, i, ga[d][i], gp[d][i], ea[d][i], ep[d][i]);
        end
      end
      checks++;
      if (ovr[d] !== eovr[d]) begin errors++; $display("FAIL ovr_flag dut%0d got %b exp %b", d, ovr[d], eovr[d]); end
    end
    checks++;
    if (ovr[0] !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b exp 1", ovr[0]); end
  endtask

  task automatic test_midframe();
    new_frame();
    add_line(8, 0);
    @(negedge CLK) cam_vsync = 1'b0;
    repeat (2) @(negedge CLK);
    drive_lines(1'b0);
    @(negedge CLK) RST = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (we[d] !== 1'b0 || addr[d] !== '0 || pix[d] !== 12'd0 || ovr[d] !== 1'b0) begin
        errors++; $display("FAIL mid_async_reset dut%0d got we=%b addr=%0d pix=%h ovr=%b exp zero", d, we[d], addr[d], pix[d], ovr[d]);
      end
    end
    @(negedge CLK) RST = 1'b0;
    eovr[0] = 1'b0;
    eovr[1] = 1'b0;
    clear_obs();
    new_frame();
    add_line(8, 0); add_line(8, 0);
    drive_lines(1'b0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ga[d].size() != 0 || fdc[d] != 0) begin
        errors++; $display("FAIL mid_ignored dut%0d got %0d writes %0d done exp 0", d, ga[d].size(), fdc[d]);
      end
    end
    clear_obs(); new_frame();
    add_line(8, 0); add_line(8, 0);
    model_frame();
    drive_frame(1'b0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ga[d].size() != ea[d].size()) begin
        errors++; $display("FAIL mid_nwrites dut%0d got %0d exp %0d", d, ga[d].size(), ea[d].size());
      end
      for (int i = 0; i < ea[d].size() && i < ga[d].size(); i++) begin
        checks++;
        if (ga[d][i] !== ea[d][i] || gp[d][i] !== ep[d][i]) begin
          errors++; $display("FAIL mid_write dut%0d #%0d got %0d/%h exp %0d/%h", d, i, ga[d][i], gp[d][i], ea[d][i], ep[d][i]);
        end
      end
      checks++;
      if (fdc[d] !== 1) begin errors++; $display("FAIL mid_frame_done dut%0d got %0d exp 1", d, fdc[d]); end
    end
  endtask

  task automatic test_decimate();
    clear_obs(); new_frame();
    for (int r = 0; r < 4; r++) add_line(16, 2);
    model_frame();
    drive_frame(1'b0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ga[d].size() != ea[d].size()) begin
        errors++; $display("FAIL dec_nwrites dut%0d got %0d exp %0d", d, ga[d].size(), ea[d].size());
      end
      for (int i = 0; i < ea[d].size() && i < ga[d].size(); i++) begin
        checks++;
        if (ga[d][i] !== ea[d][i] || gp[d][i] !== ep[d][i]) begin
          errors++; $display("FAIL dec_write dut%0d #%0d got %0d/%h exp %0d/%h", d, i, ga[d][i], gp[d][i], ea[d][i], ep[d][i]);
        end
      end
      checks++;
      if (ovr[d] !== eovr[d]) begin errors++; $display("FAIL dec_overrun dut%0d got %b exp %b", d, ovr[d], eovr[d]); end
    end
    for (int k = 0; k < ga[1].size() && k < 8; k++) begin
      checks++;
      if (gp[1][k][11:8] !== 4'(2 * (k % 4))) begin
        errors++; $display("FAIL dec_even_col #%0d got %0d exp %0d", k, gp[1][k][11:8], 2 * (k % 4));
      end
    end
  endtask

  task automatic test_abort();
    clear_obs(); new_frame();
    add_line(7, 0); add_line(1, 0);
    model_frame();
    drive_frame(1'b1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ga[d].size() != ea[d].size()) begin
        errors++; $display("FAIL abort_nwrites dut%0d got %0d exp %0d", d, ga[d].size(), ea[d].size());
      end
      for (int i = 0; i < ea[d].size() && i < ga[d].size(); i++) begin
        checks++;
        if (ga[d][i] !== ea[d][i] || gp[d][i] !== ep[d][i]) begin
          errors++; $display("FAIL abort_write dut%0d #%0d got %0d/%h exp %0d/%h", d, i, ga[d][i], gp[d][i], ea[d][i], ep[d][i]);
        end
      end
      checks++;
      if (fdc[d] !== 1) begin errors++; $display("FAIL abort_frame_done dut%0d got %0d exp 1", d, fdc[d]); end
    end
    clear_obs(); new_frame();
    add_line(8, 0); add_line(8, 0);
    model_frame();
    drive_frame(1'b0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ga[d].size() != ea[d].size()) begin
        errors++; $display("FAIL after_abort_nwrites dut%0d got %0d exp %0d", d, ga[d].size(), ea[d].size());
      end
      for (int i = 0; i < ea[d].size() && i < ga[d].size(); i++) begin
        checks++;
        if (ga[d][i] !== ea[d][i] || gp[d][i] !== ep[d][i]) begin
          errors++; $display("FAIL after_abort_write dut%0d #%0d got %0d/%h exp %0d/%h", d, i, ga[d][i], gp[d][i], ea[d][i], ep[d][i]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      int nl;
      clear_obs(); new_frame();
      nl = $urandom_range(1, 5);
      for (int r = 0; r < nl; r++) add_line($urandom_range(1, 12), 0);
      model_frame();
      drive_frame(1'b0);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (ga[d].size() != ea[d].size()) begin
          errors++; $display("FAIL rand_nwrites f%0d dut%0d got %0d exp %0d", f, d, ga[d].size(), ea[d].size());
        end
        for (int i = 0; i < ea[d].size() && i < ga[d].size(); i++) begin
          checks++;
          if (ga[d][i] !== ea[d][i] || gp[d][i] !== ep[d][i]) begin
            errors++; $display("FAIL rand_write f%0d dut%0d #%0d got %0d/%h exp %0d/%h", f, d, i, ga[d][i], gp[d][i], ea[d][i], ep[d][i]);
          end
        end
        checks++;
        if (fdc[d] !== 1) begin errors++; $display("FAIL rand_frame_done f%0d dut%0d got %0d exp 1", f, d, fdc[d]); end
        checks++;
        if (ovr[d] !== eovr[d]) begin errors++; $display("FAIL rand_overrun f%0d dut%0d got %b exp %b", f, d, ovr[d], eovr[d]); end
      end
    end
  endtask

  initial begin
    eovr[0] = 1'b0;
    eovr[1] = 1'b0;
    fdc[0] = 0;
    fdc[1] = 0;
    test_reset();
    test_basic();
    test_short_line();
    test_overrun();
    test_midframe();
    test_decimate();
    test_abort();
    test_random();
    test_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
